// File: rtl/commit_rob.sv
// In-order commit unit with a reorder buffer. Instructions get a tag (tail
// index) when they are dispatched. Completions arrive out of order by tag on
// NUM_FU channels. The head entry retires in program order to the regfile
// port, and also to the PC generator when the entry redirects. Retiring a
// redirect entry raises flush and empties the buffer.
module commit_rob #(
   parameter  int XLEN      = 32,
   parameter  int NUM_FU    = 3,
   parameter  int ROB_DEPTH = 8,
   localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     disp_tvalid,
   output logic                     disp_tready,
   input  logic [4:0]               disp_rd,
   output logic [TAG_W-1:0]         disp_tag,
   input  logic [NUM_FU-1:0]        fu_tvalid,
   output logic [NUM_FU-1:0]        fu_tready,
   input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
   input  logic [NUM_FU*XLEN-1:0]   fu_result,
   input  logic [NUM_FU-1:0]        fu_redirect,
   input  logic [NUM_FU*XLEN-1:0]   fu_target,
   output logic                     wbrf_tvalid,
   input  logic                     wbrf_tready,
   output logic [4:0]               wbrf_rd,
   output logic [XLEN-1:0]          wbrf_data,
   output logic                     wbpcg_tvalid,
   input  logic                     wbpcg_tready,
   output logic [XLEN-1:0]          wbpcg_target,
   output logic                     flush,
   output logic [TAG_W:0]           count
);

   localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

   logic [TAG_W:0]          head, tail;
   logic [TAG_W-1:0]        hidx, tidx;
   logic [ROB_DEPTH-1:0]    busy, done;
   logic [ROB_DEPTH-1:0]    redir_q;
   logic [4:0]              rd_q  [ROB_DEPTH];
   logic [XLEN-1:0]         res_q [ROB_DEPTH];
   logic [XLEN-1:0]         tgt_q [ROB_DEPTH];
   logic                    wb_sent, pc_sent;

   logic                    full, head_ready, head_redir;
   logic [4:0]              head_rd;
   logic                    wb_ok, pc_ok, retire, alloc;

   logic [ROB_DEPTH-1:0]    comp_we, comp_redir;
   logic [XLEN-1:0]         comp_res [ROB_DEPTH];
   logic [XLEN-1:0]         comp_tgt [ROB_DEPTH];

   assign hidx = head[TAG_W-1:0];
   assign tidx = tail[TAG_W-1:0];
   assign full = (head[TAG_W] != tail[TAG_W]) && (hidx == tidx);
   assign count = tail - head;

   assign head_ready = busy[hidx] && done[hidx];
   assign head_rd    = rd_q[hidx];
   assign head_redir = redir_q[hidx];

   // Each sent flag masks a handshake that is already done, so only the
   // handshakes still outstanding keep the entry at the head.
   assign wbrf_tvalid  = head_ready && (head_rd != 5'd0) && !wb_sent;
   assign wbpcg_tvalid = head_ready && head_redir && !pc_sent;
   assign wbrf_rd      = head_rd;
   assign wbrf_data    = res_q[hidx];
   assign wbpcg_target = tgt_q[hidx];

   assign wb_ok  = !wbrf_tvalid || wbrf_tready;
   assign pc_ok  = !wbpcg_tvalid || wbpcg_tready;
   assign retire = head_ready && wb_ok && pc_ok;
   assign flush  = retire && head_redir;

   assign disp_tready = !full && !flush;
   assign disp_tag    = tidx;
   assign alloc       = disp_tvalid && disp_tready;

   assign fu_tready = '1;

   // Route each completion to its entry. The loop runs from the highest channel
   // down, so when two channels carry the same tag the lowest channel wins.
   always_comb begin
      comp_we    = '0;
      comp_redir = '0;
      for (int e = 0; e < ROB_DEPTH; e++) begin
         comp_res[e] = '0;
         comp_tgt[e] = '0;
      end
      for (int i = NUM_FU-1; i >= 0; i--) begin
         if (fu_tvalid[i] && !flush && busy[fu_tag[i*TAG_W +: TAG_W]]) begin
            comp_we[fu_tag[i*TAG_W +: TAG_W]]    = 1'b1;
            comp_redir[fu_tag[i*TAG_W +: TAG_W]] = fu_redirect[i];
            comp_res[fu_tag[i*TAG_W +: TAG_W]]   = fu_result[i*XLEN +: XLEN];
            comp_tgt[fu_tag[i*TAG_W +: TAG_W]]   = fu_target[i*XLEN +: XLEN];
         end
      end
   end

   // Control state: pointers, per-entry busy/done bits, head sent flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         busy    <= '0;
         done    <= '0;
         wb_sent <= 1'b0;
         pc_sent <= 1'b0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         busy    <= '0;
         done    <= '0;
         wb_sent <= 1'b0;
         pc_sent <= 1'b0;
      end else begin
         done <= done | comp_we;
         if (retire) begin
            busy[hidx] <= 1'b0;
            head       <= head + PTR_ONE;
            wb_sent    <= 1'b0;
            pc_sent    <= 1'b0;
         end else begin
            if (wbrf_tvalid && wbrf_tready)   wb_sent <= 1'b1;
            if (wbpcg_tvalid && wbpcg_tready) pc_sent <= 1'b1;
         end
         // The allocated entry is never busy, so no completion targets it this cycle.
         if (alloc) begin
            busy[tidx] <= 1'b1;
            done[tidx] <= 1'b0;
            tail       <= tail + PTR_ONE;
         end
      end
   end

   // Entry payload. Validity comes from busy/done, so these registers need no reset.
   always_ff @(posedge clk) begin
      if (alloc) rd_q[tidx] <= disp_rd;
      for (int e = 0; e < ROB_DEPTH; e++) begin
         if (comp_we[e]) begin
            res_q[e]   <= comp_res[e];
            redir_q[e] <= comp_redir[e];
            tgt_q[e]   <= comp_tgt[e];
         end
      end
   end

endmodule

// File: doc/commit_rob.md
Name: commit_rob

Overview:
Parametrised in-order commit unit with reorder buffer; successor to the fixed four-input committer.
- Dispatcher allocates a tag per instruction.
- Any of NUM_FU execution units completes out of order by tag.
- Head entries retire strictly in program order to the regfile write port (wbrf) and, on redirect, to the PC generator (wbpcg), with a flush pulse that squashes all younger entries.

Parameters:
XLEN, 32, data/address width
NUM_FU, 3, number of completion channels (>=1)
ROB_DEPTH, 8, ROB entries (power of 2, >=2); TAG_W = $clog2(ROB_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
disp_tvalid  in  1  allocation request
disp_tready  out  1  allocation accepted when high with tvalid
disp_rd  in  5  destination register of allocated entry
disp_tag  out  TAG_W  tag assigned (= tail index), valid whenever disp_tready
fu_tvalid  in  NUM_FU  per-channel completion valid
fu_tready  out  NUM_FU  per-channel ready
fu_tag  in  NUM_FU*TAG_W  completing entry tag, channel i at [i*TAG_W +: TAG_W]
fu_result  in  NUM_FU*XLEN  result data
fu_redirect  in  NUM_FU  entry redirects control flow
fu_target  in  NUM_FU*XLEN  redirect target
wbrf_tvalid  out  1  regfile write valid
wbrf_tready  in  1  regfile write ready
wbrf_rd  out  5  register index
wbrf_data  out  XLEN  write data
wbpcg_tvalid  out  1  redirect valid
wbpcg_tready  in  1  redirect ready
wbpcg_target  out  XLEN  redirect PC
flush  out  1  one-cycle squash pulse to front end / pipelines
count  out  TAG_W+1  occupied entries

Behaviour:
- State: head/tail pointers of TAG_W+1 bits (wrap bit). Per entry: busy, done, rd, result, redirect, target. Per ROB: wb_sent and pc_sent flags for the head entry.
- Empty: head==tail. Full: MSBs differ, low bits equal. count = tail-head (modulo 2^(TAG_W+1)).
- Reset (async):
  - Pointers 0, all busy/done 0, sent flags 0.
  - Outputs: wbrf_tvalid=0, wbpcg_tvalid=0, flush=0, count=0, disp_tready=1, disp_tag=0.
- Allocate:
  - disp_tready = !full && !flush.
  - On handshake at edge: entry[tail] busy=1, done=0, rd stored; tail+1.
  - No same-cycle retire-to-allocate bypass: a full ROB reopens the cycle after a retirement.
- Complete:
  - fu_tready = all ones (combinational, never stalls).
  - fu_tvalid[i] with entry busy: set done=1 and store result/redirect/target at edge.
  - Completion to non-busy entry: ignored.
  - Two channels with the same tag in one cycle: protocol violation; lowest index wins.
  - Completions in a flush cycle: ignored.
- Retire (head entry busy && done; combinational outputs from head):
  - Normal entry, rd!=0:
    - wbrf_tvalid=1, rd/data from entry.
    - Retire on wbrf handshake: head+1, busy cleared.
  - Normal entry, rd==0: retires silently in one cycle, no wbrf_tvalid.
  - Redirect entry:
    - wbrf_tvalid (if rd!=0 && !wb_sent) and wbpcg_tvalid (if !pc_sent) asserted concurrently.
    - Each handshake sets its sent flag.
    - Entry retires in the cycle the last outstanding handshake completes.
    - That cycle: flush=1; all entries cleared; head=tail=0; sent flags cleared; an allocation that cycle is refused.
  - Maximum one retirement per cycle.
  - Latency: completion at edge t → head visible and outputs valid in cycle t+1.
- AXI-Stream rules:
  - Once asserted, tvalid and payload stay stable until handshake (head does not move).
  - tvalid never depends on tready.
- Retirement and allocation of different entries in the same cycle both proceed.
- Reset asserted mid-operation discards all state immediately; no output handshakes complete in the reset cycle.

Test Plan:
1. Reset → count=0, disp_tready=1, disp_tag=0, wbrf_tvalid=0, wbpcg_tvalid=0, flush=0. Reassert rst with 4 entries pending → same values, no writeback after release.
2. Out-of-order completion: dispatch rd=1,2,3 (tags 0,1,2); complete tag2=0x30, tag0=0x10, tag1=0x20 on different channels → wbrf sequence (1,0x10),(2,0x20),(3,0x30) on consecutive cycles.
3. Full ROB: ROB_DEPTH=8, dispatch 8 → count=8, disp_tready=0. Complete and retire tag0 → disp_tready=1 next cycle, disp_tag=0 (wrap).
4. Redirect/flush: tags 0–3 with rd=1; tag1 redirect target 0x80, result 0x44; tags 2,3 completed. → wbrf (1,res0) then (1,0x44) together with wbpcg 0x80. flush high exactly one cycle; tags 2,3 never written; count=0; next disp_tag=0.
5. Backpressure: wbrf_tready low 5 cycles, then wbpcg_tready low 3 cycles on a redirect entry → tvalids held, payload stable; flush only after both handshakes.
6. Simultaneous completions: 3 channels complete tags 0,1,2 in one cycle; tag1 has rd=0 → wbrf rd for tag0, then tag1 retires silently, then tag2 written: 3 consecutive retirement cycles.
